// File: rtl/bus_dev_tx_fifo.sv
// bus_dev_tx_fifo: per-device transmit FIFO feeding one lane of the bus arbiter.
// The device pushes packets. The bus sees the head packet on D_pop while pndng=1,
// and pops it when granted. All status outputs and D_pop are registered.
// Optional build macro BUS_FIFO_OVERWRITE_EN: when it is defined, a push into a
// full FIFO without a pop overwrites the oldest entry instead of being dropped.
module bus_dev_tx_fifo #(
  parameter int          pckg_sz   = 16,
  parameter int          depth     = 8,
  parameter logic [7:0]  broadcast = 8'hFF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   dev_push,
  input  logic [pckg_sz-1:0]     dev_data,
  output logic                   dev_full,
  input  logic                   pop,
  output logic [pckg_sz-1:0]     D_pop,
  output logic                   pndng,
  output logic [$clog2(depth):0] count,
  output logic [15:0]            ovf_cnt,
  output logic [15:0]            unf_cnt,
  output logic [15:0]            bcast_cnt
);

  localparam int AW = $clog2(depth);
  localparam int CW = AW + 1;

  logic [pckg_sz-1:0] mem_q [depth];

  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               pndng_q, pndng_d;
  logic               dev_full_q, dev_full_d;
  logic [pckg_sz-1:0] d_pop_q, d_pop_d;
  logic [15:0]        ovf_cnt_q, ovf_cnt_d;
  logic [15:0]        unf_cnt_q, unf_cnt_d;
  logic [15:0]        bcast_cnt_q, bcast_cnt_d;

  logic is_empty, is_full;
  logic wr_en, ovf_inc, unf_inc, bcast_inc, head_fwd;

  // Pointer and occupancy update for the push/pop combination. All cases are
  // decided on the occupancy before the edge.
  always_comb begin
    is_empty = (count_q == '0);
    is_full  = (count_q == CW'(depth));
    wr_en    = 1'b0;
    ovf_inc  = 1'b0;
    unf_inc  = 1'b0;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    unique case ({dev_push, pop})
      2'b10: begin
        if (!is_full) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + AW'(1);
          count_d  = count_q + CW'(1);
        end else begin
          ovf_inc  = 1'b1;
`ifdef BUS_FIFO_OVERWRITE_EN
          // The write slot equals the oldest slot when full. Advance both pointers
          // so that the next-oldest packet becomes the head.
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + AW'(1);
          rd_ptr_d = rd_ptr_q + AW'(1);
`endif
        end
      end
      2'b01: begin
        if (!is_empty) begin
          rd_ptr_d = rd_ptr_q + AW'(1);
          count_d  = count_q - CW'(1);
        end else begin
          unf_inc  = 1'b1;
        end
      end
      2'b11: begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + AW'(1);
        if (is_empty) begin
          // When empty, the pop has nothing to take. The push still lands.
          unf_inc  = 1'b1;
          count_d  = count_q + CW'(1);
        end else begin
          // A pop frees a slot, so the push is accepted even when full.
          rd_ptr_d = rd_ptr_q + AW'(1);
        end
      end
      default: ;
    endcase
  end

  // Registered head, flags and saturating statistics.
  always_comb begin
    // The new head slot can be the one that is written on this edge. In that
    // case, forward the incoming data so the registered head is correct.
    head_fwd    = wr_en && (rd_ptr_d == wr_ptr_q);
    d_pop_d     = (count_d == '0) ? '0 : (head_fwd ? dev_data : mem_q[rd_ptr_d]);
    pndng_d     = (count_d != '0);
    dev_full_d  = (count_d == CW'(depth));
    bcast_inc   = wr_en && (dev_data[pckg_sz-1 -: 8] == broadcast);
    ovf_cnt_d   = (ovf_inc   && ovf_cnt_q   != 16'hFFFF) ? ovf_cnt_q   + 16'd1 : ovf_cnt_q;
    unf_cnt_d   = (unf_inc   && unf_cnt_q   != 16'hFFFF) ? unf_cnt_q   + 16'd1 : unf_cnt_q;
    bcast_cnt_d = (bcast_inc && bcast_cnt_q != 16'hFFFF) ? bcast_cnt_q + 16'd1 : bcast_cnt_q;
  end

  // Packet storage. Reset does not clear it because the contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) mem_q[wr_ptr_q] <= dev_data;
  end

  // Control and status state with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      pndng_q     <= 1'b0;
      dev_full_q  <= 1'b0;
      d_pop_q     <= '0;
      ovf_cnt_q   <= '0;
      unf_cnt_q   <= '0;
      bcast_cnt_q <= '0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      pndng_q     <= pndng_d;
      dev_full_q  <= dev_full_d;
      d_pop_q     <= d_pop_d;
      ovf_cnt_q   <= ovf_cnt_d;
      unf_cnt_q   <= unf_cnt_d;
      bcast_cnt_q <= bcast_cnt_d;
    end
  end

  assign D_pop     = d_pop_q;
  assign pndng     = pndng_q;
  assign dev_full  = dev_full_q;
  assign count     = count_q;
  assign ovf_cnt   = ovf_cnt_q;
  assign unf_cnt   = unf_cnt_q;
  assign bcast_cnt = bcast_cnt_q;

endmodule

// File: tb/tb_bus_dev_tx_fifo.sv
// Testbench for bus_dev_tx_fifo. It runs directed scenarios, then random traffic.
// A queue-based reference model predicts every output after each clock edge.
module tb_bus_dev_tx_fifo;
  localparam int         PW    = 16;
  localparam int         DEPTH = 8;
  localparam logic [7:0] BC    = 8'hFF;

  logic          clk = 1'b0;
  logic          reset, dev_push, pop;
  logic [PW-1:0] dev_data;
  logic          dev_full, pndng;
  logic [PW-1:0] D_pop;
  logic [$clog2(DEPTH):0] count;
  logic [15:0]   ovf_cnt, unf_cnt, bcast_cnt;

  bus_dev_tx_fifo #(.pckg_sz(PW), .depth(DEPTH), .broadcast(BC)) dut (
    .clk(clk), .reset(reset), .dev_push(dev_push), .dev_data(dev_data),
    .dev_full(dev_full), .pop(pop), .D_pop(D_pop), .pndng(pndng), .count(count),
    .ovf_cnt(ovf_cnt), .unf_cnt(unf_cnt), .bcast_cnt(bcast_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: packet queue plus statistics.
  logic [PW-1:0] mq[$];
  int m_ovf, m_unf, m_bc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic void sat_inc(ref int c);
    if (c < 65535) c++;
  endfunction

  function automatic void model(input logic p, input logic [PW-1:0] d, input logic pp, input logic r);
    int n;
    if (r) begin
      mq.delete(); m_ovf = 0; m_unf = 0; m_bc = 0;
      return;
    end
    n = mq.size();
    if (pp) begin
      if (n > 0) void'(mq.pop_front());
      else sat_inc(m_unf);
    end
    if (p) begin
      if (n < DEPTH || (pp && n > 0)) begin
        mq.push_back(d);
        if (d[PW-1 -: 8] == BC) sat_inc(m_bc);
      end else begin
        sat_inc(m_ovf);
`ifdef BUS_FIFO_OVERWRITE_EN
        void'(mq.pop_front());
        mq.push_back(d);
        if (d[PW-1 -: 8] == BC) sat_inc(m_bc);
`endif
      end
    end
  endfunction

  task automatic check_all();
    chk("count",    32'(count),     32'(mq.size()));
    chk("pndng",    32'(pndng),     32'(mq.size() != 0));
    chk("dev_full", 32'(dev_full),  32'(mq.size() == DEPTH));
    chk("D_pop",    32'(D_pop),     (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
    chk("ovf_cnt",  32'(ovf_cnt),   32'(m_ovf));
    chk("unf_cnt",  32'(unf_cnt),   32'(m_unf));
    chk("bcast",    32'(bcast_cnt), 32'(m_bc));
  endtask

  // Drive one cycle of inputs, advance the model on the edge, and check #1 after the edge.
  task automatic step(input logic p, input logic [PW-1:0] d, input logic pp, input logic r);
    dev_push = p; dev_data = d; pop = pp; reset = r;
    @(posedge clk);
    model(p, d, pp, r);
    #1;
    check_all();
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, '0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [PW-1:0] d;
    logic [PW-1:0] exp_head;
    dev_push = 0; dev_data = '0; pop = 0; reset = 1;

    // Reset, then idle.
    do_reset();
    repeat (5) idle();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_dpop",  32'(D_pop), 32'd0);

    // Single push, then a pop three edges later.
    step(1'b1, 16'h0208, 1'b0, 1'b0);
    chk("push_lat_dpop", 32'(D_pop), 32'h0208);
    chk("push_lat_pnd",  32'(pndng), 32'd1);
    idle(); idle();
    step(1'b0, '0, 1'b1, 1'b0);
    chk("pop_empty_pnd", 32'(pndng), 32'd0);
    chk("pop_empty_dp",  32'(D_pop), 32'd0);

    // Fill the FIFO, overflow it, then drain it across the wrap point.
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 16'h0101 + 16'(i), 1'b0, 1'b0);
    chk("fill_full",  32'(dev_full), 32'd1);
    chk("fill_count", 32'(count),    32'd8);
    step(1'b1, 16'h01FF, 1'b0, 1'b0);
    chk("ovf_one", 32'(ovf_cnt), 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
`ifdef BUS_FIFO_OVERWRITE_EN
      exp_head = (i < DEPTH-1) ? 16'h0102 + 16'(i) : 16'h01FF;
`else
      exp_head = 16'h0101 + 16'(i);
`endif
      chk("drain_head", 32'(D_pop), 32'(exp_head));
      step(1'b0, '0, 1'b1, 1'b0);
    end

    // Simultaneous push and pop while full.
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 16'h0101 + 16'(i), 1'b0, 1'b0);
    step(1'b1, 16'h0A0A, 1'b1, 1'b0);
    chk("pp_full_cnt", 32'(count),   32'd8);
    chk("pp_full_ovf", 32'(ovf_cnt), 32'd0);
    chk("pp_full_hd",  32'(D_pop),   32'h0102);
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH-1) chk("pp_last", 32'(D_pop), 32'h0A0A);
      step(1'b0, '0, 1'b1, 1'b0);
    end

    // Empty FIFO: pop alone, then push and pop together.
    do_reset();
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 16'h5A5A, 1'b1, 1'b0);
    chk("unf_two",  32'(unf_cnt), 32'd2);
    chk("unf_cnt1", 32'(count),   32'd1);
    chk("unf_dpop", 32'(D_pop),   32'h5A5A);

    // Broadcast counting, then a reset mid-stream while a push is active.
    do_reset();
    step(1'b1, 16'hFF33, 1'b0, 1'b0);
    step(1'b1, 16'h0233, 1'b0, 1'b0);
    chk("bc_before", 32'(bcast_cnt), 32'd1);
    step(1'b1, 16'hFF44, 1'b0, 1'b1);
    chk("rst_mid_cnt", 32'(count),     32'd0);
    chk("rst_mid_bc",  32'(bcast_cnt), 32'd0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      d = 16'($urandom);
      if ($urandom_range(0, 3) == 0) d[PW-1 -: 8] = BC;
      step($urandom_range(0, 99) < 55, d, $urandom_range(0, 99) < 45,
           $urandom_range(0, 299) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
